// File: rtl/mprj_io_cfg_pkg.sv
// mprj_io_cfg_pkg
//  Shared definitions for the GPIO pad configuration controller:
//  - cfg_state_t : sequencer states (IDLE, SHIFT, LOAD)
//  - CFG_*       : bit offsets of the fields inside one pad config word
//  - calc_nb()   : bits shifted per chain, set by the longer of the two chains
package mprj_io_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } cfg_state_t;

    // Field layout of a 13-bit pad config word (LSB first).
    localparam int CFG_MGMT_EN   = 0;
    localparam int CFG_OEB       = 1;
    localparam int CFG_HOLD_OVR  = 2;
    localparam int CFG_INP_DIS   = 3;
    localparam int CFG_IB_MODE   = 4;
    localparam int CFG_ANA_EN    = 5;
    localparam int CFG_ANA_SEL   = 6;
    localparam int CFG_ANA_POL   = 7;
    localparam int CFG_SLOW      = 8;
    localparam int CFG_VTRIP     = 9;
    localparam int CFG_DM_LSB    = 10;
    localparam int CFG_DM_W      = 3;

    // Both chains shift the same number of bits; the shorter one is padded.
    function automatic int calc_nb(input int total_pads, input int area1_pads, input int cfg_w);
        int area2_pads;
        area2_pads = total_pads - area1_pads;
        return ((area1_pads > area2_pads) ? area1_pads : area2_pads) * cfg_w;
    endfunction

endpackage

// File: rtl/mprj_io_cfg_serializer.sv
// mprj_io_cfg_serializer
//  Sequencer for one shift/load pass over the pad chains.
//  Ports:
//   clk, srst      clock, synchronous active-high reset
//   start          begin a pass (only honoured while idle)
//   busy           pass in progress (SHIFT or LOAD)
//   done           1-cycle pulse on the first idle cycle after LOAD
//   shift_active   high while in SHIFT; bit_idx is meaningful then
//   bit_idx        index of the bit currently on the chains (0 = first sent)
//   serial_clock   low CLK_DIV cycles, high CLK_DIV cycles per bit
//   serial_load    high CLK_DIV cycles, low CLK_DIV cycles during LOAD
module mprj_io_cfg_serializer
    import mprj_io_cfg_pkg::*;
#(
    parameter  int NB      = 8,
    parameter  int CLK_DIV = 1,
    localparam int BW      = $clog2(NB + 1)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          shift_active,
    output logic [BW-1:0] bit_idx,
    output logic          serial_clock,
    output logic          serial_load
);

    localparam int PHW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(CLK_DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(NB - 1);

    cfg_state_t     state_reg, state_next;
    logic [PHW-1:0] phase_reg, phase_next;
    logic           high_reg, high_next;   // 0 = low half of the period, 1 = high half
    logic [BW-1:0]  bit_reg, bit_next;
    logic           done_reg, done_next;
    logic           half_end;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            high_reg  <= 1'b0;
            bit_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            high_reg  <= high_next;
            bit_reg   <= bit_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        high_next    = high_reg;
        bit_next     = bit_reg;
        done_next    = 1'b0;
        serial_clock = 1'b0;
        serial_load  = 1'b0;
        half_end     = (phase_reg == PHASE_LAST);
        busy         = (state_reg != IDLE);
        shift_active = (state_reg == SHIFT);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    phase_next = '0;
                    high_next  = 1'b0;
                    bit_next   = '0;
                end
            end
            SHIFT: begin
                serial_clock = high_reg;
                if (half_end) begin
                    phase_next = '0;
                    high_next  = !high_reg;
                    // The bit index advances only when a high half ends, so the
                    // chain data changes exactly at the start of a low half.
                    if (high_reg) begin
                        bit_next = bit_reg + BW'(1);
                        if (bit_reg == BIT_LAST) begin
                            state_next = LOAD;
                        end
                    end
                end else begin
                    phase_next = phase_reg + PHW'(1);
                end
            end
            LOAD: begin
                // Reuses the divider: strobe during the first half, quiet during the second.
                serial_load = !high_reg;
                if (half_end) begin
                    phase_next = '0;
                    high_next  = !high_reg;
                    if (high_reg) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    phase_next = phase_reg + PHW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bit_idx = bit_reg;
    assign done    = done_reg;

endmodule

// File: rtl/mprj_io_cfg_ctrl.sv
// mprj_io_cfg_ctrl
//  Configuration controller for the user-project GPIO pads. Keeps a shadow
//  config word per pad and, on request, shifts all words out over two
//  serial chains followed by a load strobe.
//  Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   cfg_valid/ready/pad/data   shadow write port; cfg_err pulses for a bad index
//   apply_valid/ready          start a shift/load pass
//   busy, done                 pass in progress / 1-cycle end pulse
//   rd_pad, rd_data            combinational shadow readback (0 when out of range)
//   serial_clock/load/data_1/2 chain interface
module mprj_io_cfg_ctrl
    import mprj_io_cfg_pkg::*;
#(
    parameter  int                TOTAL_PADS = 38,
    parameter  int                AREA1PADS  = 19,
    parameter  int                CFG_W      = 13,
    parameter  int                CLK_DIV    = 4,
    parameter  logic [CFG_W-1:0]  RESET_CFG  = CFG_W'(13'h0403),
    localparam int                PW         = $clog2(TOTAL_PADS)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PW-1:0]    cfg_pad,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             apply_valid,
    output logic             apply_ready,
    output logic             busy,
    output logic             done,
    input  logic [PW-1:0]    rd_pad,
    output logic [CFG_W-1:0] rd_data,
    output logic             serial_clock,
    output logic             serial_load,
    output logic             serial_data_1,
    output logic             serial_data_2
);

    localparam int NB   = calc_nb(TOTAL_PADS, AREA1PADS, CFG_W);
    localparam int BW   = $clog2(NB + 1);
    localparam int PAD1 = NB - AREA1PADS * CFG_W;                 // leading zeros on chain 1
    localparam int PAD2 = NB - (TOTAL_PADS - AREA1PADS) * CFG_W;  // leading zeros on chain 2

    logic [CFG_W-1:0] shadow_reg [TOTAL_PADS];
    logic             cfg_err_reg;
    logic [31:0]      cfg_pad_ext;
    logic [31:0]      rd_pad_ext;
    logic             wr_fire;
    logic             pad_oob;
    logic             start;
    logic             shift_active;
    logic [BW-1:0]    bit_idx;
    // Chain streams in transmit order: element k is the bit sent at step k.
    logic [NB-1:0]    chain1_vec;
    logic [NB-1:0]    chain2_vec;

    assign cfg_ready   = !busy;
    assign apply_ready = !busy;
    assign wr_fire     = cfg_valid && cfg_ready;
    assign start       = apply_valid && apply_ready;
    assign cfg_pad_ext = 32'(cfg_pad);
    assign rd_pad_ext  = 32'(rd_pad);
    assign pad_oob     = (cfg_pad_ext >= 32'(TOTAL_PADS));
    assign cfg_err     = cfg_err_reg;

    // A write accepted together with an apply lands on this same edge, so the
    // pass that starts here already sees the new word.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int p = 0; p < TOTAL_PADS; p++) begin
                shadow_reg[p] <= RESET_CFG;
            end
            cfg_err_reg <= 1'b0;
        end else begin
            for (int p = 0; p < TOTAL_PADS; p++) begin
                if (wr_fire && (cfg_pad_ext == 32'(p))) begin
                    shadow_reg[p] <= cfg_data;
                end
            end
            cfg_err_reg <= wr_fire && pad_oob;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < TOTAL_PADS; p++) begin
            if (rd_pad_ext == 32'(p)) begin
                rd_data = shadow_reg[p];
            end
        end
    end

    // Chain 1 sends pad AREA1PADS-1 first down to pad 0; chain 2 sends pad
    // AREA1PADS first up to TOTAL_PADS-1. Words go MSB first, and the shorter
    // chain is front-padded so its real data ends on the last bit.
    genvar gi, gj;
    generate
        for (gi = 0; gi < PAD1; gi++) begin : g_pad1
            assign chain1_vec[gi] = 1'b0;
        end
        for (gi = 0; gi < PAD2; gi++) begin : g_pad2
            assign chain2_vec[gi] = 1'b0;
        end
        for (gi = 0; gi < AREA1PADS; gi++) begin : g_chain1
            localparam int BASE = PAD1 + (AREA1PADS - 1 - gi) * CFG_W;
            for (gj = 0; gj < CFG_W; gj++) begin : g_bit
                assign chain1_vec[BASE + gj] = shadow_reg[gi][CFG_W - 1 - gj];
            end
        end
        for (gi = AREA1PADS; gi < TOTAL_PADS; gi++) begin : g_chain2
            localparam int BASE = PAD2 + (gi - AREA1PADS) * CFG_W;
            for (gj = 0; gj < CFG_W; gj++) begin : g_bit
                assign chain2_vec[BASE + gj] = shadow_reg[gi][CFG_W - 1 - gj];
            end
        end
    endgenerate

    // Outside SHIFT both data lines are held at 0.
    always_comb begin
        serial_data_1 = 1'b0;
        serial_data_2 = 1'b0;
        if (shift_active) begin
            for (int k = 0; k < NB; k++) begin
                if (bit_idx == BW'(k)) begin
                    serial_data_1 = chain1_vec[k];
                    serial_data_2 = chain2_vec[k];
                end
            end
        end
    end

    mprj_io_cfg_serializer #(
        .NB      (NB),
        .CLK_DIV (CLK_DIV)
    ) u_serializer (
        .clk          (wb_clk_i),
        .srst         (wb_rst_i),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .shift_active (shift_active),
        .bit_idx      (bit_idx),
        .serial_clock (serial_clock),
        .serial_load  (serial_load)
    );

endmodule

// File: tb/tb_mprj_io_cfg_ctrl.sv
// tb_mprj_io_cfg_ctrl
//  Directed bench. Instance A: 4 pads, split 2/2, 4-bit words, CLK_DIV=1, NB=8.
//  Instance B: 5 pads, split 2/3, 4-bit words, CLK_DIV=3, NB=12 (chain 1 padded).
module tb_mprj_io_cfg_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A
    logic       a_rst, a_cfg_valid, a_apply;
    logic [1:0] a_cfg_pad, a_rd_pad;
    logic [3:0] a_cfg_data, a_rd_data;
    logic       a_cfg_ready, a_cfg_err, a_apply_ready, a_busy, a_done;
    logic       a_sc, a_sl, a_sd1, a_sd2;

    // Instance B
    logic       b_rst, b_cfg_valid, b_apply;
    logic [2:0] b_cfg_pad, b_rd_pad;
    logic [3:0] b_cfg_data, b_rd_data;
    logic       b_cfg_ready, b_cfg_err, b_apply_ready, b_busy, b_done;
    logic       b_sc, b_sl, b_sd1, b_sd2;

    mprj_io_cfg_ctrl #(
        .TOTAL_PADS(4), .AREA1PADS(2), .CFG_W(4), .CLK_DIV(1), .RESET_CFG(4'h3)
    ) u_a (
        .wb_clk_i(clk), .wb_rst_i(a_rst),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_pad(a_cfg_pad),
        .cfg_data(a_cfg_data), .cfg_err(a_cfg_err),
        .apply_valid(a_apply), .apply_ready(a_apply_ready),
        .busy(a_busy), .done(a_done),
        .rd_pad(a_rd_pad), .rd_data(a_rd_data),
        .serial_clock(a_sc), .serial_load(a_sl),
        .serial_data_1(a_sd1), .serial_data_2(a_sd2)
    );

    mprj_io_cfg_ctrl #(
        .TOTAL_PADS(5), .AREA1PADS(2), .CFG_W(4), .CLK_DIV(3), .RESET_CFG(4'h3)
    ) u_b (
        .wb_clk_i(clk), .wb_rst_i(b_rst),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_pad(b_cfg_pad),
        .cfg_data(b_cfg_data), .cfg_err(b_cfg_err),
        .apply_valid(b_apply), .apply_ready(b_apply_ready),
        .busy(b_busy), .done(b_done),
        .rd_pad(b_rd_pad), .rd_data(b_rd_data),
        .serial_clock(b_sc), .serial_load(b_sl),
        .serial_data_1(b_sd1), .serial_data_2(b_sd2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic a_write(input logic [1:0] pad, input logic [3:0] data);
        a_cfg_valid = 1'b1;
        a_cfg_pad   = pad;
        a_cfg_data  = data;
        @(negedge clk);
        a_cfg_valid = 1'b0;
    endtask

    task automatic b_write(input logic [2:0] pad, input logic [3:0] data);
        b_cfg_valid = 1'b1;
        b_cfg_pad   = pad;
        b_cfg_data  = data;
        @(negedge clk);
        b_cfg_valid = 1'b0;
    endtask

    // Runs one pass on A; optionally writes pad3=F alongside the apply and
    // pokes writes/applies during the first busy cycles.
    task automatic a_seq(input bit wr_same, input bit poke,
                         output logic [7:0] c1, output logic [7:0] c2,
                         output int busy_n, output int load_n, output int done_n,
                         output int gap, output int ready_bad);
        logic prev_sc;
        int   last_busy, done_at;
        c1 = '0; c2 = '0; busy_n = 0; load_n = 0; done_n = 0; ready_bad = 0;
        prev_sc = 1'b0; last_busy = -100; done_at = -1;
        a_apply = 1'b1;
        if (wr_same) begin
            a_cfg_valid = 1'b1; a_cfg_pad = 2'd3; a_cfg_data = 4'hF;
        end
        @(negedge clk);
        a_apply = 1'b0; a_cfg_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && done_n == 0; cyc++) begin
            if (a_busy) begin
                busy_n++; last_busy = cyc;
                if (a_cfg_ready || a_apply_ready) ready_bad++;
            end
            if (a_sc && !prev_sc) begin
                c1 = {c1[6:0], a_sd1};
                c2 = {c2[6:0], a_sd2};
            end
            prev_sc = a_sc;
            if (a_sl) load_n++;
            if (a_done) begin done_n++; done_at = cyc; end
            if (poke && cyc < 3) begin
                a_cfg_valid = 1'b1; a_cfg_pad = 2'd0; a_cfg_data = 4'h0; a_apply = 1'b1;
            end else begin
                a_cfg_valid = 1'b0; a_apply = 1'b0;
            end
            @(negedge clk);
        end
        a_cfg_valid = 1'b0; a_apply = 1'b0;
        gap = done_at - last_busy;
    endtask

    // Runs one pass on B and measures serial_clock half-period lengths.
    task automatic b_seq(output logic [11:0] c1, output logic [11:0] c2,
                         output int busy_n, output int load_n, output int done_n,
                         output int gap, output int hi_min, output int hi_max,
                         output int lo_min, output int lo_max);
        logic prev_sc;
        int   last_busy, done_at, run;
        c1 = '0; c2 = '0; busy_n = 0; load_n = 0; done_n = 0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
        prev_sc = 1'b0; last_busy = -100; done_at = -1; run = 0;
        b_apply = 1'b1;
        @(negedge clk);
        b_apply = 1'b0;
        for (int cyc = 0; cyc < 200 && done_n == 0; cyc++) begin
            if (b_busy) begin
                busy_n++; last_busy = cyc;
                if (b_sc == prev_sc) begin
                    run++;
                end else begin
                    if (prev_sc) begin
                        if (run < hi_min) hi_min = run;
                        if (run > hi_max) hi_max = run;
                    end else begin
                        if (run < lo_min) lo_min = run;
                        if (run > lo_max) lo_max = run;
                    end
                    run = 1;
                end
            end
            if (b_sc && !prev_sc) begin
                c1 = {c1[10:0], b_sd1};
                c2 = {c2[10:0], b_sd2};
            end
            prev_sc = b_sc;
            if (b_sl) load_n++;
            if (b_done) begin done_n++; done_at = cyc; end
            @(negedge clk);
        end
        gap = done_at - last_busy;
    endtask

    logic [7:0]  c1, c2;
    logic [11:0] d1, d2;
    int busy_n, load_n, done_n, gap, ready_bad;
    int hi_min, hi_max, lo_min, lo_max;
    int seen;

    initial begin
        a_rst = 1'b1; a_cfg_valid = 1'b0; a_apply = 1'b0;
        a_cfg_pad = '0; a_cfg_data = '0; a_rd_pad = '0;
        b_rst = 1'b1; b_cfg_valid = 1'b0; b_apply = 1'b0;
        b_cfg_pad = '0; b_cfg_data = '0; b_rd_pad = '0;
        repeat (3) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Reset state: {busy,done,cfg_err,sclk,sload,sd1,sd2} all 0, ready high.
        check("a_rst_outs", {a_busy, a_done, a_cfg_err, a_sc, a_sl, a_sd1, a_sd2}, 0);
        check("a_rst_ready", {a_cfg_ready, a_apply_ready}, 2'b11);
        check("a_rst_rd0", a_rd_data, 4'h3);
        a_rd_pad = 2'd3; #1;
        check("a_rst_rd3", a_rd_data, 4'h3);
        check("b_rst_outs", {b_busy, b_done, b_cfg_err, b_sc, b_sl, b_sd1, b_sd2}, 0);
        @(negedge clk);

        // 1: pass with reset words: both chains 0011_0011, 2*1*(8+1) busy cycles.
        a_seq(1'b0, 1'b0, c1, c2, busy_n, load_n, done_n, gap, ready_bad);
        check("t1_chain1", c1, 8'h33);
        check("t1_chain2", c2, 8'h33);
        check("t1_busy", busy_n, 18);
        check("t1_load", load_n, 1);
        check("t1_done", done_n, 1);
        check("t1_done_gap", gap, 1);
        check("t1_ready_bsy", ready_bad, 0);
        check("t1_after", {a_done, a_busy}, 2'b00);

        // 2: distinct words per pad.
        a_write(2'd0, 4'hA);
        a_write(2'd1, 4'h5);
        a_write(2'd2, 4'hC);
        a_write(2'd3, 4'h1);
        check("t2_err", a_cfg_err, 1'b0);
        a_rd_pad = 2'd1; #1;
        check("t2_rd1", a_rd_data, 4'h5);
        a_rd_pad = 2'd2; #1;
        check("t2_rd2", a_rd_data, 4'hC);
        @(negedge clk);
        a_seq(1'b0, 1'b0, c1, c2, busy_n, load_n, done_n, gap, ready_bad);
        check("t2_chain1", c1, 8'h5A);
        check("t2_chain2", c2, 8'hC1);
        check("t2_busy", busy_n, 18);

        // 4: same-cycle write pad3=F with apply; pokes during busy are ignored.
        a_seq(1'b1, 1'b1, c1, c2, busy_n, load_n, done_n, gap, ready_bad);
        check("t4_chain1", c1, 8'h5A);
        check("t4_chain2", c2, 8'hCF);
        check("t4_ready_bsy", ready_bad, 0);
        check("t4_busy", busy_n, 18);
        check("t4_after", {a_done, a_busy}, 2'b00);
        @(negedge clk);
        check("t4_no_rerun", a_busy, 1'b0);
        a_rd_pad = 2'd0; #1;
        check("t4_rd0", a_rd_data, 4'hA);
        a_rd_pad = 2'd3; #1;
        check("t4_rd3", a_rd_data, 4'hF);
        @(negedge clk);

        // 5: reset during bit 1 high phase (chain1 bit1=1, chain2 bit1=1).
        a_apply = 1'b1;
        @(negedge clk);
        a_apply = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pre", {a_busy, a_sc, a_sd1, a_sd2}, 4'b1111);
        a_rst = 1'b1; a_rd_pad = 2'd0;
        @(negedge clk);
        check("t5_outs", {a_busy, a_done, a_cfg_err, a_sc, a_sl, a_sd1, a_sd2}, 0);
        check("t5_rd0", a_rd_data, 4'h3);
        a_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_done || a_busy) seen++;
        end
        check("t5_no_done", seen, 0);

        // 3: out-of-range writes on B (5 pads, PW=3).
        b_write(3'd5, 4'hF);
        check("t3_err5_on", b_cfg_err, 1'b1);
        @(negedge clk);
        check("t3_err5_off", b_cfg_err, 1'b0);
        b_write(3'd7, 4'hF);
        check("t3_err7_on", b_cfg_err, 1'b1);
        @(negedge clk);
        check("t3_err7_off", b_cfg_err, 1'b0);
        b_rd_pad = 3'd7; #1;
        check("t3_rd7", b_rd_data, 4'h0);
        b_rd_pad = 3'd4; #1;
        check("t3_rd4", b_rd_data, 4'h3);
        @(negedge clk);
        b_write(3'd0, 4'h9);
        b_write(3'd1, 4'h6);
        b_write(3'd2, 4'h8);
        b_write(3'd3, 4'h0);
        b_write(3'd4, 4'h7);
        check("t3_err_ok", b_cfg_err, 1'b0);

        // 3/6: chain 1 gets 4 leading zeros; CLK_DIV=3 -> 3/3 phases, 6*13 busy.
        b_seq(d1, d2, busy_n, load_n, done_n, gap, hi_min, hi_max, lo_min, lo_max);
        check("t3_chain1", d1, 12'h069);
        check("t3_chain2", d2, 12'h807);
        check("t6_busy", busy_n, 78);
        check("t6_load", load_n, 3);
        check("t6_done", done_n, 1);
        check("t6_done_gap", gap, 1);
        check("t6_hi_range", {hi_min[7:0], hi_max[7:0]}, 16'h0303);
        check("t6_lo_range", {lo_min[7:0], lo_max[7:0]}, 16'h0303);
        check("t6_after", {b_done, b_busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
